// File: rtl/mon_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// mon_fifo_ctrl
// Controller for the 2048 x 18 monitor trace buffer. Four capture sources
// share the RAM write port through a round-robin arbiter; each stored word is
// {source_id[1:0], data[15:0]}. The UART reader drains the buffer with an
// empty / rdreq / rdack handshake, supplying its own sequential address.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wreq[3:0]       per-source write request (level, held until wack)
//   wdat[63:0]      source i data on wdat[16i+15:16i]
//   wack[3:0]       one-cycle write acknowledge, one-hot or zero
//   ram_we/_waddr/_wdata   RAM write port
//   ram_raddr       RAM read address (copy of raddr)
//   ram_rdata       RAM read data, one cycle after address
//   empty, full     buffer status flags
//   rdreq/rdack     read handshake; rdata valid during rdack
//   raddr           reader-supplied read address
//   rdata           copy of ram_rdata
//   count           entries stored, 0..2048
//   ovf             sticky: a write request was stalled by full
// ---------------------------------------------------------------------------
module mon_fifo_ctrl #(
    parameter int NREQ = 4,
    parameter int AW   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wreq,
    input  logic [16*NREQ-1:0]   wdat,
    output logic [NREQ-1:0]      wack,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_waddr,
    output logic [17:0]          ram_wdata,
    output logic [AW-1:0]        ram_raddr,
    input  logic [17:0]          ram_rdata,
    output logic                 empty,
    input  logic                 rdreq,
    output logic                 rdack,
    input  logic [AW-1:0]        raddr,
    output logic [17:0]          rdata,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 ovf
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic            we_q, we_d;
    logic [NREQ-1:0] wack_q, wack_d;
    logic [17:0]     wdata_q, wdata_d;
    logic            rdack_q, rdack_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [NREQ-1:0] elig;
    logic [AW+1:0]   occ;
    logic            space_ok;
    logic            gnt_found;
    logic [1:0]      gnt_id;
    logic [1:0]      idx;
    logic            rd_accept;

    // Round-robin grant. The source acked this cycle still shows its old
    // request level, so it is masked out. Occupancy counts the write that
    // commits this cycle, since count_q does not include it yet.
    always_comb begin
        elig      = wreq & ~wack_q;
        occ       = {1'b0, count_q} + (AW+2)'(we_q);
        space_ok  = occ < (AW+2)'(DEPTH);
        gnt_found = 1'b0;
        gnt_id    = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_grant_q + 2'(k);
            if (!gnt_found && space_ok && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        we_d    = gnt_found;
        wack_d  = '0;
        wdata_d = wdata_q;
        if (gnt_found) begin
            wack_d[gnt_id] = 1'b1;
            wdata_d        = {gnt_id, wdat[16*gnt_id +: 16]};
        end

        rd_accept = rdreq & ~empty_q & ~rdack_q;
        rdack_d   = rd_accept;
        rd_addr_d = rd_accept ? raddr : rd_addr_q;

        wptr_d       = wptr_q + (AW+1)'(we_q);
        last_grant_d = we_q ? wdata_q[17:16] : last_grant_q;

        // The reader's address replaces rptr; the MSB carries through the wrap.
        rptr_d = rdack_q ? ({rptr_q[AW], rd_addr_q} + (AW+1)'(1)) : rptr_q;

        // Status is computed from the next pointers so flags line up with
        // the pointer registers.
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        count_d = wptr_d - rptr_d;
        ovf_d   = ovf_q | (full_q & (|wreq));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            last_grant_q <= 2'd3;
            we_q         <= 1'b0;
            wack_q       <= '0;
            wdata_q      <= '0;
            rdack_q      <= 1'b0;
            rd_addr_q    <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wack_q       <= wack_d;
            wdata_q      <= wdata_d;
            rdack_q      <= rdack_d;
            rd_addr_q    <= rd_addr_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign wack      = wack_q;
    assign ram_we    = we_q;
    assign ram_waddr = wptr_q[AW-1:0];
    assign ram_wdata = wdata_q;
    assign ram_raddr = raddr;
    assign rdack     = rdack_q;
    assign rdata     = ram_rdata;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule
